mult_acc: RTL
=============

Name: mult_acc

Overview:
- Downstream consumer of the sequential multiplier `mult`. Takes each finished product (`result` / `result_rdy`) and accumulates LEN consecutive products into one dot-product sum.
- Presents the sum on a valid/ack output register.
- Sits between the multiplier and the result sink. The multiplier is never stalled; loss of a sum is flagged instead.

Parameters:
- N, 8, multiplier operand-1 width
- M, 8, multiplier operand-2 width
- LEN, 4, products per group (2..256)
- ACC_W, N+M+$clog2(LEN), accumulator/output width; may be set smaller than full growth

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- result_rdy  input  1  multiplier done level; held high for ≥1 cycle per product
- result  input  N+M  unsigned product, valid while result_rdy high
- clr  input  1  synchronous abort of the partial group
- acc_ack  input  1  sink accepts acc_out this cycle
- acc_vld  output  1  acc_out holds a completed group sum
- acc_out  output  ACC_W  completed group sum
- grp_idx  output  $clog2(LEN)  number of products in the current partial group
- ovf  output  1  sticky: a completed sum was dropped
- sat  output  1  sticky: saturation occurred (0 when feature compiled out)

Behaviour:
- Reset (asynchronous, active-low) clears: acc_vld=0, acc_out=0, grp_idx=0, ovf=0, sat=0, internal accumulator=0, state=S_IDLE.
  - The internal delayed copy rdy_d resets to 1, so a result_rdy level held across reset release is NOT counted.
  - Reset mid-group discards the partial sum.
- Product capture:
  - A product is taken only on the rising edge of result_rdy (result_rdy=1 && rdy_d=0), one product per pulse regardless of pulse length.
  - result is sampled in that same cycle.
- FSM:
  - S_IDLE (grp_idx=0, acc=0): on capture → acc=result, grp_idx=1, go to S_ACC. With LEN=1 the group completes immediately instead.
  - S_ACC: on capture → acc+=result, grp_idx++. On the LEN-th product the group completes: acc=0, grp_idx=0, go to S_IDLE.
- Latency: acc_vld rises on the clock edge following the capture cycle of the LEN-th product, with acc_out equal to the full sum.
- Output handshake:
  - acc_vld and acc_out hold until a cycle with acc_vld && acc_ack; acc_vld falls on the following edge.
  - A completion in the same cycle as an ack loads the new sum and keeps acc_vld=1.
  - A completion while acc_vld=1 and acc_ack=0: the new sum is dropped, acc_out is unchanged, ovf is set. The new group still starts cleanly.
- clr:
  - Forces acc=0, grp_idx=0, state=S_IDLE. Does not affect acc_vld, acc_out, ovf or sat.
  - clr and a capture in the same cycle: clr wins over the old partial; the captured product becomes product #1 of the new group.
- Arithmetic: unsigned. Full-width sum = N+M+$clog2(LEN) bits. If ACC_W is smaller than that, the sum wraps modulo 2^ACC_W unless the optional feature is enabled.
- ovf and sat clear only on reset.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined:
  - Each accumulate step clamps to 2^ACC_W-1 when the true sum exceeds it.
  - A clamped group stays at max for the rest of the group.
  - sat is set on the first clamp.
- Undefined:
  - Modulo wrap.
  - sat is tied to 0.

Decomposition:
- Shared package mult_pkg holds:
  - defaults N_DEF=8, M_DEF=8, LEN_DEF=4
  - state typedef (S_IDLE, S_ACC)
  - function acc_width(N,M,LEN)
- One natural sub-module, rdy_edge: the rising-edge detector with reset-to-1 history. Accumulation, FSM and output register stay in mult_acc.

Test Plan:
- Defaults, products 25×5, 20×16, 8×7, 6×1 driven through `mult` → one acc_vld with acc_out=507; grp_idx back to 0.
- result_rdy held high 3 cycles per product, products 10,10,10,10 → acc_out=40. A 20-cycle-long pulse counts once.
- clr asserted after 2 products (125, 320), then 56, 6, 144, 1 → acc_out=207. clr coincident with product 56 → acc_out still 207 (56 counted).
- acc_ack held 0, two full groups of 1s → acc_out=4, acc_vld=1, ovf=1 after the second group. Ack with a completion in the same cycle → new sum replaces, acc_vld stays 1.
- ACC_W=9, products 200,200,200,6 → with MULT_ACC_SAT_EN acc_out=511 and sat=1; without it acc_out=94 and sat=0.
- rstn pulsed low after 2 products while result_rdy high → all outputs 0. No capture at release. The next full group sums correctly.

Source files
------------

// File: rtl/mult_acc_pkg.sv
// Shared types and defaults for the multiplier back-end blocks.
package mult_pkg;
  localparam int N_DEF   = 8;
  localparam int M_DEF   = 8;
  localparam int LEN_DEF = 4;

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  // Width that holds LEN full-scale products without loss.
  function automatic int acc_width(int n, int m, int len);
    return n + m + $clog2(len);
  endfunction
endpackage

// File: rtl/mult_acc_if.sv
// Product-in / sum-out bundle between multiplier, accumulator and sink.
interface mult_acc_if #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int ACC_W = 18
);
  logic             result_rdy;
  logic [N+M-1:0]   result;
  logic             acc_ack;
  logic             acc_vld;
  logic [ACC_W-1:0] acc_out;

  modport master (output result_rdy, result, acc_ack, input acc_vld, acc_out);
  modport slave  (input result_rdy, result, acc_ack, output acc_vld, acc_out);
endinterface

// File: rtl/mult_acc_rdy_edge.sv
// Rising-edge detect on result_rdy; history resets high so a level held
// across reset release is not taken as a new product.
module rdy_edge (
  input  logic clk,
  input  logic rstn,
  input  logic lvl_i,
  output logic rise_o
);
  logic rdy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_q <= 1'b1;
    else       rdy_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~rdy_q;
endmodule

// File: rtl/mult_acc.sv
// Dot-product accumulator: sums LEN products into one valid/ack sum.
// Define MULT_ACC_SAT_EN to clamp at 2^ACC_W-1 instead of wrapping.
module mult_acc
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int ACC_W = acc_width(N, M, LEN),
  localparam int GW   = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  mult_acc_if.slave     bus,
  input  logic          clr,
  output logic [GW-1:0] grp_idx,
  output logic          ovf,
  output logic          sat
);
  localparam int CW = $clog2(LEN + 1);
  localparam int SW = ((ACC_W > N + M) ? ACC_W : N + M) + 1;

  logic cap;
  rdy_edge u_edge (.clk(clk), .rstn(rstn), .lvl_i(bus.result_rdy), .rise_o(cap));

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_q, out_d;
  logic [GW-1:0]    grp_q, grp_d;
  logic             vld_q, vld_d, ovf_q, ovf_d, sat_q, sat_d;

  logic             keep, clamp, done;
  logic [ACC_W-1:0] base, step;
  logic [CW-1:0]    cnt_base, cnt_nxt;
  logic [SW-1:0]    sum_w;

  // clr discards the old partial, so a coincident capture starts a new group.
  always_comb begin
    keep     = (state_q == S_ACC) && !clr;
    base     = keep ? acc_q : '0;
    cnt_base = keep ? CW'(grp_q) : '0;
    cnt_nxt  = cnt_base + CW'(1);
    sum_w    = SW'(base) + SW'(bus.result);
  end

`ifdef MULT_ACC_SAT_EN
  localparam logic [SW-1:0] MAXV = SW'({ACC_W{1'b1}});
  assign clamp = (sum_w > MAXV);
  assign step  = clamp ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign clamp = 1'b0;
  assign step  = ACC_W'(sum_w);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    vld_d   = vld_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    done    = 1'b0;

    if (vld_q && bus.acc_ack) vld_d = 1'b0;

    if (cap) begin
      sat_d = sat_q | clamp;
      if (cnt_nxt == CW'(LEN)) begin
        done    = 1'b1;
        state_d = S_IDLE;
        acc_d   = '0;
        grp_d   = '0;
      end else begin
        state_d = S_ACC;
        acc_d   = step;
        grp_d   = GW'(cnt_nxt);
      end
    end else if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      grp_d   = '0;
    end

    // Output slot frees in the same cycle it is acked; otherwise the sum is lost.
    if (done) begin
      if (!vld_q || bus.acc_ack) begin
        vld_d = 1'b1;
        out_d = step;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      grp_q   <= '0;
      vld_q   <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      grp_q   <= grp_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.acc_vld = vld_q;
  assign bus.acc_out = out_q;
  assign grp_idx     = grp_q;
  assign ovf         = ovf_q;
  assign sat         = sat_q;
endmodule
